// File: rtl/whack_pkg.sv
// -----------------------------------------------------------------------------
// whack_pkg
// Shared definitions for the whack-a-mole score keeper: FSM state encoding,
// base point values for the two hit kinds, score width and the saturating
// score adder.
// -----------------------------------------------------------------------------
package whack_pkg;

  localparam int SCORE_W = 14;

  // Base points before the streak multiplier is applied.
  localparam logic [4:0] BASE_NON_FULL = 5'd1;
  localparam logic [4:0] BASE_FULL     = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAYING   = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_e;

  // Adds a small point value to the score, clamping at the ceiling instead of
  // wrapping. One extra bit on the sum makes the overflow visible.
  function automatic logic [SCORE_W-1:0] sat_add(
    input logic [SCORE_W-1:0] a,
    input logic [4:0]         b,
    input logic [SCORE_W-1:0] ceiling
  );
    logic [SCORE_W:0]   sum;
    logic [SCORE_W-1:0] res;
    sum = {1'b0, a} + {{(SCORE_W-4){1'b0}}, b};
    if (sum > {1'b0, ceiling}) begin
      res = ceiling;
    end else begin
      res = sum[SCORE_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// -----------------------------------------------------------------------------
// score_keeper_if
// Bundles the game-event inputs and the scoreboard outputs of score_keeper.
//   master : the game side (drives start / hit / miss pulses, sees outputs)
//   slave  : the score keeper itself
// Signals:
//   start, miss, non_full_clear_hit, full_clear_hit   game events
//   game_in_progress, score, high_score, lives,
//   streak, game_over, new_high_score                 scoreboard state
// -----------------------------------------------------------------------------
interface score_keeper_if;

  logic                          start;
  logic                          miss;
  logic                          non_full_clear_hit;
  logic                          full_clear_hit;
  logic                          game_in_progress;
  logic [whack_pkg::SCORE_W-1:0] score;
  logic [whack_pkg::SCORE_W-1:0] high_score;
  logic [2:0]                    lives;
  logic [1:0]                    streak;
  logic                          game_over;
  logic                          new_high_score;

  modport master (
    output start, miss, non_full_clear_hit, full_clear_hit,
    input  game_in_progress, score, high_score, lives, streak,
           game_over, new_high_score
  );

  modport slave (
    input  start, miss, non_full_clear_hit, full_clear_hit,
    output game_in_progress, score, high_score, lives, streak,
           game_over, new_high_score
  );

endinterface

// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
// Game state machine (IDLE -> PLAYING -> GAME_OVER -> IDLE) that scores hits
// with a streak multiplier, counts down lives on misses, tracks the best score
// since reset and holds the final result for HOLD_CYCLES before idling.
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    score_keeper_if.slave (event inputs, registered scoreboard outputs)
// -----------------------------------------------------------------------------
module score_keeper
  import whack_pkg::*;
#(
  parameter int NUM_LIVES   = 3,
  parameter int MAX_SCORE   = 9999,
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int STREAK_MAX  = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  score_keeper_if.slave  bus
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] MAX_SCORE_C = SCORE_W'(MAX_SCORE);
  localparam logic [2:0]         NUM_LIVES_C = 3'(NUM_LIVES);
  localparam logic [1:0]         STREAK_MAX_C = 2'(STREAK_MAX);

  state_e               state_q;
  logic                 start_q;
  logic [SCORE_W-1:0]   score_q;
  logic [SCORE_W-1:0]   high_score_q;
  logic [2:0]           lives_q;
  logic [1:0]           streak_q;
  logic                 gip_q;
  logic                 game_over_q;
  logic                 new_high_q;
  logic [HOLD_W-1:0]    hold_q;

  logic                 start_edge_s;
  logic [4:0]           base_s;
  logic [4:0]           mult_s;
  logic [4:0]           points_s;
  logic [SCORE_W-1:0]   score_d;
  logic [2:0]           lives_d;
  logic [1:0]           streak_d;

  // Next-state scoring for one PLAYING cycle; points use the pre-update streak.
  always_comb begin
    start_edge_s = bus.start & ~start_q;
    if (bus.full_clear_hit) begin
      base_s = BASE_FULL;
    end else if (bus.non_full_clear_hit) begin
      base_s = BASE_NON_FULL;
    end else begin
      base_s = 5'd0;
    end
    mult_s   = {3'b000, streak_q} + 5'd1;
    points_s = base_s * mult_s;          // at most 5 x 4 = 20
    score_d  = sat_add(score_q, points_s, MAX_SCORE_C);
    if (bus.miss) begin
      lives_d  = lives_q - 3'd1;
      streak_d = 2'd0;
    end else if (bus.full_clear_hit | bus.non_full_clear_hit) begin
      lives_d  = lives_q;
      streak_d = (streak_q >= STREAK_MAX_C) ? STREAK_MAX_C : streak_q + 2'd1;
    end else begin
      lives_d  = lives_q;
      streak_d = streak_q;
    end
  end

  // Game FSM with all scoreboard outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      score_q      <= '0;
      high_score_q <= '0;
      lives_q      <= 3'd0;
      streak_q     <= 2'd0;
      gip_q        <= 1'b0;
      game_over_q  <= 1'b0;
      new_high_q   <= 1'b0;
      hold_q       <= '0;
    end else begin
      start_q     <= bus.start;
      game_over_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_edge_s) begin
            state_q    <= ST_PLAYING;
            gip_q      <= 1'b1;
            score_q    <= '0;
            lives_q    <= NUM_LIVES_C;
            streak_q   <= 2'd0;
            new_high_q <= 1'b0;
          end
        end
        ST_PLAYING: begin
          score_q  <= score_d;
          lives_q  <= lives_d;
          streak_q <= streak_d;
          // Last life lost: the final hit in this cycle still counts toward
          // the high-score comparison.
          if (bus.miss && (lives_q == 3'd1)) begin
            state_q     <= ST_GAME_OVER;
            gip_q       <= 1'b0;
            game_over_q <= 1'b1;
            hold_q      <= '0;
            if (score_d > high_score_q) begin
              high_score_q <= score_d;
              new_high_q   <= 1'b1;
            end
          end
        end
        ST_GAME_OVER: begin
          if (hold_q == HOLD_LAST) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gip_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.game_in_progress = gip_q;
  assign bus.score            = score_q;
  assign bus.high_score       = high_score_q;
  assign bus.lives            = lives_q;
  assign bus.streak           = streak_q;
  assign bus.game_over        = game_over_q;
  assign bus.new_high_score   = new_high_q;

endmodule

// File: tb/tb_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_score_keeper
// Two score keepers (MAX_SCORE 9999 and 10) share one random/directed event
// stream. A driver pushes the expected post-edge scoreboard from a rule-level
// game model into per-DUT queues; a monitor pops and compares after each edge.
// -----------------------------------------------------------------------------
module tb_score_keeper;

  localparam int NL   = 3;
  localparam int HOLD = 4;
  localparam int SMAX = 3;

  typedef struct packed {
    logic        gip;
    logic [13:0] score;
    logic [13:0] high;
    logic [2:0]  lives;
    logic [1:0]  streak;
    logic        go;
    logic        nhs;
  } obs_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  score_keeper_if ifa();
  score_keeper_if ifb();

  score_keeper #(.NUM_LIVES(NL), .MAX_SCORE(9999), .HOLD_CYCLES(HOLD), .STREAK_MAX(SMAX))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  score_keeper #(.NUM_LIVES(NL), .MAX_SCORE(10), .HOLD_CYCLES(HOLD), .STREAK_MAX(SMAX))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Game model: phase 0 idle, 1 playing, 2 showing the result.
  int mx[2];
  int ph[2];
  int sc[2];
  int hi[2];
  int lv[2];
  int sk[2];
  int remain[2];
  bit gov[2];
  bit nh[2];
  bit prev[2];

  obs_t exp_a[$];
  obs_t exp_b[$];
  obs_t ea;
  obs_t eb;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ph[d] = 0; sc[d] = 0; hi[d] = 0; lv[d] = 0; sk[d] = 0;
      remain[d] = 0; gov[d] = 1'b0; nh[d] = 1'b0; prev[d] = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input bit s, input bit m, input bit nf, input bit fc);
    int pts;
    gov[d] = 1'b0;
    if (ph[d] == 0) begin
      if (s && !prev[d]) begin
        ph[d] = 1; sc[d] = 0; lv[d] = NL; sk[d] = 0; nh[d] = 1'b0;
      end
    end else if (ph[d] == 1) begin
      pts = 0;
      if (fc) pts = 5 * (1 + sk[d]);
      else if (nf) pts = 1 + sk[d];
      sc[d] = (sc[d] + pts > mx[d]) ? mx[d] : sc[d] + pts;
      if (m) begin
        lv[d] = lv[d] - 1;
        sk[d] = 0;
      end else if (fc || nf) begin
        sk[d] = (sk[d] < SMAX) ? sk[d] + 1 : SMAX;
      end
      if (lv[d] == 0) begin
        ph[d] = 2; remain[d] = HOLD; gov[d] = 1'b1;
        if (sc[d] > hi[d]) begin
          hi[d] = sc[d]; nh[d] = 1'b1;
        end
      end
    end else begin
      remain[d] = remain[d] - 1;
      if (remain[d] == 0) ph[d] = 0;
    end
    prev[d] = s;
  endtask

  function automatic obs_t model_obs(input int d);
    obs_t o;
    o.gip = (ph[d] == 1); o.score = 14'(sc[d]); o.high = 14'(hi[d]);
    o.lives = 3'(lv[d]); o.streak = 2'(sk[d]); o.go = gov[d]; o.nhs = nh[d];
    return o;
  endfunction

  function automatic obs_t get_a();
    obs_t o;
    o.gip = ifa.game_in_progress; o.score = ifa.score; o.high = ifa.high_score;
    o.lives = ifa.lives; o.streak = ifa.streak; o.go = ifa.game_over; o.nhs = ifa.new_high_score;
    return o;
  endfunction

  function automatic obs_t get_b();
    obs_t o;
    o.gip = ifb.game_in_progress; o.score = ifb.score; o.high = ifb.high_score;
    o.lives = ifb.lives; o.streak = ifb.streak; o.go = ifb.game_over; o.nhs = ifb.new_high_score;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t: got gip=%0d score=%0d hi=%0d lives=%0d streak=%0d go=%0d nhs=%0d; want gip=%0d score=%0d hi=%0d lives=%0d streak=%0d go=%0d nhs=%0d",
               name, $time, act.gip, act.score, act.high, act.lives, act.streak, act.go, act.nhs,
               exp.gip, exp.score, exp.high, exp.lives, exp.streak, exp.go, exp.nhs);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of events at the falling edge and queue the expected result.
  task automatic cycle(input bit s, input bit m, input bit nf, input bit fc);
    @(negedge clk);
    ifa.start = s; ifa.miss = m; ifa.non_full_clear_hit = nf; ifa.full_clear_hit = fc;
    ifb.start = s; ifb.miss = m; ifb.non_full_clear_hit = nf; ifb.full_clear_hit = fc;
    model_step(0, s, m, nf, fc);
    model_step(1, s, m, nf, fc);
    exp_a.push_back(model_obs(0));
    exp_b.push_back(model_obs(1));
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    obs_t z;
    z = '0;
    @(negedge clk);
    ifa.start = 1'b0; ifa.miss = 1'b0; ifa.non_full_clear_hit = 1'b0; ifa.full_clear_hit = 1'b0;
    ifb.start = 1'b0; ifb.miss = 1'b0; ifb.non_full_clear_hit = 1'b0; ifb.full_clear_hit = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_obs("async_reset_A", get_a(), z);
    check_obs("async_reset_B", get_b(), z);
    model_reset();
    @(negedge clk);
    check_obs("held_reset_A", get_a(), z);
    check_obs("held_reset_B", get_b(), z);
    #2 rst_n = 1'b1;
  endtask

  // Scoreboard monitor: compare each queued expectation just after its edge.
  always @(posedge clk) begin
    #1;
    if (exp_a.size() > 0) begin
      ea = exp_a.pop_front();
      check_obs("scb_A", get_a(), ea);
    end
    if (exp_b.size() > 0) begin
      eb = exp_b.pop_front();
      check_obs("scb_B", get_b(), eb);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t z;
    z = '0;
    checks = 0; failures = 0;
    mx[0] = 9999; mx[1] = 10;
    rst_n = 1'b0;
    ifa.start = 1'b0; ifa.miss = 1'b0; ifa.non_full_clear_hit = 1'b0; ifa.full_clear_hit = 1'b0;
    ifb.start = 1'b0; ifb.miss = 1'b0; ifb.non_full_clear_hit = 1'b0; ifb.full_clear_hit = 1'b0;
    model_reset();
    #3;
    check_obs("por_A", get_a(), z);
    check_obs("por_B", get_b(), z);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Start, then streak-multiplied hits.
    cycle(1'b1, 1'b0, 1'b0, 1'b0); settle();
    check_val("start_gip", ifa.game_in_progress, 1);
    check_val("start_lives", ifa.lives, 3);
    check_val("start_score", ifa.score, 0);
    check_val("start_streak", ifa.streak, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1); settle();
    check_val("score_26", ifa.score, 26);
    check_val("streak_cap", ifa.streak, 3);
    check_val("sat_B_10", ifb.score, 10);
    cycle(1'b1, 1'b0, 1'b1, 1'b0); settle();
    check_val("score_30_start_ignored", ifa.score, 30);
    // Build streak 2, then hit and miss together.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0); settle();
    check_val("hitmiss_score", ifa.score, 36);
    check_val("hitmiss_lives", ifa.lives, 1);
    check_val("hitmiss_streak", ifa.streak, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0); settle();
    check_val("over_gip", ifa.game_in_progress, 0);
    check_val("over_pulse", ifa.game_over, 1);
    check_val("over_high", ifa.high_score, 36);
    check_val("over_nhs", ifa.new_high_score, 1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0); settle();
    check_val("hold_gip", ifa.game_in_progress, 0);
    check_val("idle_score_kept", ifa.score, 36);
    cycle(1'b1, 1'b0, 1'b0, 1'b0); settle();
    check_val("restart_gip", ifa.game_in_progress, 1);
    check_val("restart_nhs", ifa.new_high_score, 0);
    check_val("restart_high", ifa.high_score, 36);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();

    // Random event stream.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_val("queues_drained", exp_a.size() + exp_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter NUM_LIVES, default 3, lives granted at game start (range 1..7).
REQ-002 Parameter MAX_SCORE, default 9999, saturation ceiling of score.
REQ-003 Parameter HOLD_CYCLES, default 100_000_000, GAME_OVER dwell before return to IDLE.
REQ-004 Parameter STREAK_MAX, default 3, streak cap; multiplier = 1 + streak.
REQ-005 clk  input  1  single system clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  debounced level from start button; only its rising edge is used.
REQ-008 miss  input  1  one-cycle pulse from the hit_logic stage: miss occurred.
REQ-009 non_full_clear_hit  input  1  one-cycle pulse: hit with moles still up.
REQ-010 full_clear_hit  input  1  one-cycle pulse: hit that cleared all moles.
REQ-011 game_in_progress  output  1  high only in PLAYING; drives the hit_logic stage.
REQ-012 score  output  14  current game score, binary.
REQ-013 high_score  output  14  best score since reset.
REQ-014 lives  output  3  remaining lives.
REQ-015 streak  output  2  consecutive hits without a miss, capped at STREAK_MAX.
REQ-016 game_over  output  1  one-cycle pulse on entry to GAME_OVER.
REQ-017 new_high_score  output  1  level, high while the latest finished game set high_score.

Function
REQ-018 FSM states SHALL be IDLE, PLAYING, GAME_OVER; all outputs registered.
REQ-019 IDLE: start rising edge (start=1, previous start=0) -> PLAYING next edge; score=0, lives=NUM_LIVES, streak=0, new_high_score=0 loaded at that edge.
REQ-020 start held high SHALL NOT retrigger; a start rising edge in PLAYING SHALL be ignored.
REQ-021 PLAYING: input pulse in cycle N SHALL be reflected in score/lives/streak after the edge ending cycle N (1-cycle latency).
REQ-022 Hit points: non_full_clear_hit base 1, full_clear_hit base 5; points = base x (1 + current streak).
REQ-023 If both hit pulses assert together, full_clear_hit SHALL take precedence; one hit counted.
REQ-024 On a hit without miss, streak SHALL increment, saturating at STREAK_MAX.
REQ-025 On miss, lives SHALL decrement by 1 and streak SHALL clear to 0.
REQ-026 Hit and miss in the same cycle: points computed with pre-update streak, then lives-1 and streak=0.
REQ-027 score SHALL saturate at MAX_SCORE; no wrap.
REQ-028 Miss taking lives to 0 -> GAME_OVER at the same edge; game_in_progress low from that edge.
REQ-029 Entry to GAME_OVER: game_over=1 for exactly one cycle; if score > high_score then high_score=score and new_high_score=1 (equal score does not update).
REQ-030 GAME_OVER: score, lives, streak held; hold counter runs; start ignored; after HOLD_CYCLES cycles -> IDLE.
REQ-031 IDLE keeps score and new_high_score displayed until the next start edge.
REQ-032 Input pulses outside PLAYING SHALL be ignored.

Reset
REQ-033 rst_n low SHALL immediately force: IDLE, score=0, high_score=0, lives=0, streak=0, game_in_progress=0, game_over=0, new_high_score=0, hold counter=0, start history=0.
REQ-034 Reset asserted mid-PLAYING SHALL abort the game with no game_over pulse and no high_score update.
REQ-035 First start edge is recognised no earlier than the first clock after rst_n deassertion.

Structure
REQ-036 Shared package whack_pkg SHALL hold the FSM state enum, base point constants (1, 5) and score width (14).
REQ-037 Single module; no sub-module is natural (edge detect, multiplier and saturating add are inline).

Verification (NUM_LIVES=3, MAX_SCORE=9999, HOLD_CYCLES=4, STREAK_MAX=3)
REQ-038 Reset, start pulse -> next cycle game_in_progress=1, lives=3, score=0, streak=0.
REQ-039 Three non_full hits then one full_clear hit -> score 1+2+3+20=26, streak=3; a further non_full hit -> 30.
REQ-040 Streak=2, simultaneous non_full_clear_hit and miss -> score +3, lives 3->2, streak=0.
REQ-041 Three misses -> game_in_progress=0 and game_over=1 after the third; high_score=score, new_high_score=1; start during the 4 hold cycles ignored; IDLE after 4 cycles, then start accepted.
REQ-042 MAX_SCORE=10, streak=3, score=8, full_clear_hit -> score=10.
REQ-043 rst_n pulsed low mid-PLAYING -> all outputs at reset values asynchronously, no game_over pulse.
